// File: rtl/ps2_device_tx.sv
// ps2_device_tx: device-to-host PS/2 transmitter with an 8-entry byte FIFO.
// Define PS2_TX_ERR_INJ_EN to let i_err_inj invert the parity bit of a frame.
module ps2_device_tx #(
    parameter int CLK_HALF   = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       i_clk,
    input  logic       i_clr_n,
    input  logic       i_wr_n,
    input  logic [7:0] i_data,
    input  logic       i_err_inj,
    output logic       o_ps2_clk,
    output logic       o_ps2_data,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_busy,
    output logic       o_overflow
);
    localparam int MAXC = (CLK_HALF > GAP_CYCLES) ? CLK_HALF : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, GAP} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_mem [8];
    logic [2:0]    r_wr_ptr, r_rd_ptr;
    logic [3:0]    r_count;
    logic [CW-1:0] r_tmr, w_tmr_nxt;
    logic [3:0]    r_bit, w_bit_nxt;
    logic [10:0]   r_shreg, w_shreg_nxt;
    logic          r_ps2_clk, r_ps2_data, r_overflow;
    logic          w_wr, w_pop, w_inj, w_frame_active;
    logic [7:0]    w_head;

    assign o_full     = r_count == 4'd8;
    assign o_empty    = r_count == 4'd0;
    assign o_busy     = r_state != IDLE;
    assign o_ps2_clk  = r_ps2_clk;
    assign o_ps2_data = r_ps2_data;
    assign o_overflow = r_overflow;

    // Full is judged on the pre-edge count, so a write on a popping edge while full is dropped.
    assign w_wr   = !i_wr_n && !o_full;
    assign w_pop  = r_state == LOAD;
    assign w_head = r_mem[r_rd_ptr];

`ifdef PS2_TX_ERR_INJ_EN
    assign w_inj = i_err_inj;
`else
    logic w_unused_err_inj;
    assign w_unused_err_inj = i_err_inj;
    assign w_inj = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 3'd1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 3'd1;
            r_count <= r_count + {3'd0, w_wr} - {3'd0, w_pop};
            if (!i_wr_n && o_full) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        case (r_state)
            IDLE: if (!o_empty) w_state_nxt = LOAD;
            LOAD: begin
                w_shreg_nxt = {1'b1, ~^w_head ^ w_inj, w_head, 1'b0};
                w_bit_nxt   = '0;
                w_tmr_nxt   = HALF_LAST;
                w_state_nxt = HIGH;
            end
            HIGH: begin
                w_tmr_nxt   = (r_tmr == '0) ? HALF_LAST : r_tmr - CW'(1);
                w_state_nxt = (r_tmr == '0) ? LOW : HIGH;
            end
            LOW: begin
                if (r_tmr == '0) begin
                    w_shreg_nxt = {1'b1, r_shreg[10:1]};
                    w_bit_nxt   = r_bit + 4'd1;
                    w_tmr_nxt   = (r_bit == 4'd10) ? GAP_LAST : HALF_LAST;
                    w_state_nxt = (r_bit == 4'd10) ? GAP : HIGH;
                end else begin
                    w_tmr_nxt = r_tmr - CW'(1);
                end
            end
            GAP: begin
                w_tmr_nxt   = (r_tmr == '0) ? r_tmr : r_tmr - CW'(1);
                w_state_nxt = (r_tmr == '0) ? IDLE : GAP;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Line outputs are registered from the next state so they switch on the same edge as the FSM.
    assign w_frame_active = (w_state_nxt == HIGH) || (w_state_nxt == LOW);

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state    <= IDLE;
            r_tmr      <= '0;
            r_bit      <= '0;
            r_shreg    <= '1;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_tmr      <= w_tmr_nxt;
            r_bit      <= w_bit_nxt;
            r_shreg    <= w_shreg_nxt;
            r_ps2_clk  <= w_state_nxt != LOW;
            r_ps2_data <= w_frame_active ? w_shreg_nxt[0] : 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_device_tx.sv
// tb_ps2_device_tx: checks ps2_device_tx against a frame-timeline model and a PS/2 host decoder.
module tb_ps2_device_tx;
    localparam int CH        = 4;
    localparam int GAP       = 8;
    localparam int FRAME_LEN = 1 + 22 * CH + GAP;

    logic       clk = 0, clr_n = 1, wr_n = 1, err_inj = 0;
    logic [7:0] data = 0;
    logic       ps2_clk, ps2_data, full, empty, busy, ovf;
    int         checks = 0, errors = 0, cyc = 0;

    ps2_device_tx #(.CLK_HALF(CH), .GAP_CYCLES(GAP)) dut (
        .i_clk(clk), .i_clr_n(clr_n), .i_wr_n(wr_n), .i_data(data), .i_err_inj(err_inj),
        .o_ps2_clk(ps2_clk), .o_ps2_data(ps2_data), .o_full(full), .o_empty(empty),
        .o_busy(busy), .o_overflow(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Model: a byte queue plus the position inside the current frame (-1 = idle, 0 = load cycle).
    logic [7:0]  mq[$];
    int          pos = -1;
    logic        m_ovf = 0, m_full_pre, m_empty_pre, m_inj;
    logic [7:0]  m_byte;
    logic [10:0] m_frame = '1;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mq.delete();
            pos = -1;
            m_ovf = 0;
        end else begin
            m_full_pre = mq.size() == 8;
            m_empty_pre = mq.size() == 0;
`ifdef PS2_TX_ERR_INJ_EN
            m_inj = err_inj;
`else
            m_inj = 0;
`endif
            if (pos == 0) begin
                m_byte = mq.pop_front();
                m_frame = {1'b1, ~^m_byte ^ m_inj, m_byte, 1'b0};
            end
            if (!wr_n) begin
                if (m_full_pre) m_ovf = 1;
                else mq.push_back(data);
            end
            if (pos >= 0) pos = (pos == FRAME_LEN - 1) ? -1 : pos + 1;
            else if (!m_empty_pre) pos = 0;
        end
    end

    function automatic logic [5:0] expected();
        int   k;
        logic c = 1, d = 1;
        if (pos >= 1 && pos <= 22 * CH) begin
            k = pos - 1;
            c = (k % (2 * CH)) < CH;
            d = m_frame[k / (2 * CH)];
        end
        return {c, d, mq.size() == 8, mq.size() == 0, pos >= 0, m_ovf};
    endfunction

    logic [5:0] e_out, a_out;
    always @(negedge clk) begin
        e_out = expected();
        a_out = {ps2_clk, ps2_data, full, empty, busy, ovf};
        checks++;
        if (a_out !== e_out) begin
            errors++;
            $display("FAIL outputs cyc=%0d act=%b exp=%b (clk,data,full,empty,busy,ovf)", cyc, a_out, e_out);
        end
    end

    // Host-side decoder: samples data on each falling PS/2 clock edge.
    int          nbits = 0, falls = 0, perr = 0;
    logic [10:0] fr = '0, last_frame = '0;
    logic [7:0]  rxq[$];
    int          starts[$];

    always @(negedge ps2_clk or negedge clr_n) begin
        if (!clr_n) nbits = 0;
        else begin
            if (nbits == 0) starts.push_back(cyc);
            fr[nbits] = ps2_data;
            nbits++;
            falls++;
            if (nbits == 11) begin
                nbits = 0;
                last_frame = fr;
                if (!fr[0] && fr[10] && ^fr[9:1]) rxq.push_back(fr[8:1]);
                else perr++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b);
        wr_n = 0;
        data = b;
        @(negedge clk);
        wr_n = 1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(empty && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(n < budget), 1);
    endtask

    initial begin
        int t0, f0, r0, n, p0;
        #1 clr_n = 0;
        tick(3);
        chk("rst_ps2_clk", ps2_clk, 1);
        chk("rst_ps2_data", ps2_data, 1);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        clr_n = 1;
        tick(2);

        rxq.delete(); starts.delete(); f0 = falls;
        put(8'h1C);
        t0 = cyc;
        wait_idle("single_idle", 400);
        tick(2);
        chk("single_falls", falls - f0, 11);
        chk("single_bits", last_frame, 11'b100_0011_1000);
        chk("single_frames", starts.size(), 1);
        if (starts.size() > 0) chk("single_first_fall", starts[0] - t0, 6);
        chk("single_rx_count", rxq.size(), 1);
        if (rxq.size() > 0) chk("single_rx", rxq[0], 8'h1C);

        rxq.delete(); starts.delete();
        put(8'h1C); put(8'hF0); put(8'h1C);
        wait_idle("loop_idle", 600);
        chk("loop_count", rxq.size(), 3);
        if (rxq.size() == 3) begin
            chk("loop_b0", rxq[0], 8'h1C);
            chk("loop_b1", rxq[1], 8'hF0);
            chk("loop_b2", rxq[2], 8'h1C);
        end
        if (starts.size() == 3) begin
            chk("loop_pitch01", starts[1] - starts[0], 98);
            chk("loop_pitch12", starts[2] - starts[1], 98);
        end
        chk("loop_ovf", ovf, 0);

        rxq.delete();
        for (int i = 1; i <= 9; i++) put(8'(i));
        chk("ovf_full_after9", full, 1);
        chk("ovf_pre", ovf, 0);
        put(8'h0A);
        chk("ovf_set", ovf, 1);
        wait_idle("ovf_idle", 1500);
        chk("ovf_rx_count", rxq.size(), 9);
        for (int i = 0; i < 9 && i < rxq.size(); i++) chk("ovf_rx", rxq[i], i + 1);
        chk("ovf_end_empty", empty, 1);
        chk("ovf_end_busy", busy, 0);

        rxq.delete();
        put(8'h55);
        n = 0;
        while (nbits < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_bit4", int'(n < 200), 1);
        @(posedge clk);
        #2 clr_n = 0;
        #1;
        chk("rst_mid_ps2_clk", ps2_clk, 1);
        chk("rst_mid_ps2_data", ps2_data, 1);
        chk("rst_mid_empty", empty, 1);
        chk("rst_mid_busy", busy, 0);
        @(negedge clk);
        clr_n = 1;
        f0 = falls;
        r0 = rxq.size();
        tick(300);
        chk("rst_no_edges", falls - f0, 0);
        chk("rst_no_rx", rxq.size() - r0, 0);

        rxq.delete();
        for (int i = 0; i < 9; i++) put(8'hA0 + 8'(i));
        chk("col_full", full, 1);
        chk("col_ovf_pre", ovf, 0);
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("col_reach_idle", int'(n < 300), 1);
        @(negedge clk);
        chk("col_load_busy", busy, 1);
        chk("col_load_full", full, 1);
        put(8'hEE);
        chk("col_ovf", ovf, 1);
        chk("col_full_after", full, 0);
        wait_idle("col_idle", 1500);
        chk("col_rx_count", rxq.size(), 9);
        for (int i = 0; i < 9 && i < rxq.size(); i++) chk("col_rx", rxq[i], 8'hA0 + i);

        rxq.delete();
        p0 = perr;
        err_inj = 1;
        put(8'h1C);
        wait_idle("inj_idle", 400);
        err_inj = 0;
`ifdef PS2_TX_ERR_INJ_EN
        chk("inj_parity_bit", last_frame[9], 1);
        chk("inj_rx_count", rxq.size(), 0);
        chk("inj_perr", perr - p0, 1);
`else
        chk("inj_parity_bit", last_frame[9], 0);
        chk("inj_rx_count", rxq.size(), 1);
        if (rxq.size() > 0) chk("inj_rx", rxq[0], 8'h1C);
`endif
        put(8'h32);
        wait_idle("inj_next_idle", 400);
        chk("inj_next_nonempty", int'(rxq.size() > 0), 1);
        if (rxq.size() > 0) chk("inj_next_rx", rxq[rxq.size() - 1], 8'h32);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
